// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame and animation counters.
//
// Ports:
//   vga_clk      : pixel clock; every register updates on its rising edge
//   Reset        : synchronous, active-low reset
//   hs, vs       : horizontal / vertical sync, active low
//   blank        : 1 while the current pixel is visible, 0 during blanking
//   DrawX, DrawY : current pixel column / row
//   frame_start  : one-cycle pulse when the raster wraps back to (0,0)
//   vblank_start : one-cycle pulse at (0,V_VISIBLE)
//   frame_count  : free-running 6-bit frame counter
//   anim_tick    : one-cycle pulse every ANIM_DIV frames
//   anim_frame   : sprite animation index, 0..ANIM_FRAMES-1
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ANIM_DIV    = 4,
    parameter int ANIM_FRAMES = 6
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [5:0] frame_count,
    output logic       anim_tick,
    output logic [5:0] anim_frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [5:0]       AF_LAST  = 6'(ANIM_FRAMES - 1);

    logic [9:0]       hc;
    logic [9:0]       vc;
    logic [9:0]       hc_n;
    logic [9:0]       vc_n;
    logic             h_wrap;
    logic [DIV_W-1:0] div;

    assign DrawX = hc;
    assign DrawY = vc;

    always_comb begin
        h_wrap = (hc == H_LAST);
        hc_n   = h_wrap ? 10'd0 : hc + 10'd1;
        vc_n   = vc;
        if (h_wrap) begin
            vc_n = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
    end

    // Sync, blank and the pixel pulses are decoded from the next counter
    // values so they land in the same cycle as the matching DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (!Reset) begin
            hc           <= '0;
            vc           <= '0;
            hs           <= 1'b1;
            vs           <= 1'b1;
            blank        <= 1'b1;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
            anim_tick    <= 1'b0;
            anim_frame   <= '0;
            div          <= '0;
        end else begin
            hc           <= hc_n;
            vc           <= vc_n;
            hs           <= !(hc_n >= HS_BEG && hc_n < HS_END);
            vs           <= !(vc_n >= VS_BEG && vc_n < VS_END);
            blank        <= (hc_n < H_VIS) && (vc_n < V_VIS);
            frame_start  <= (hc_n == 10'd0) && (vc_n == 10'd0);
            vblank_start <= (hc_n == 10'd0) && (vc_n == V_VIS);
            anim_tick    <= 1'b0;
            // Frame bookkeeping reacts to the registered vblank pulse, so
            // it settles one cycle after vblank_start is seen outside.
            if (vblank_start) begin
                frame_count <= frame_count + 6'd1;
                if (div == DIV_LAST) begin
                    div        <= '0;
                    anim_tick  <= 1'b1;
                    anim_frame <= (anim_frame == AF_LAST) ? 6'd0
                                                          : anim_frame + 6'd1;
                end else begin
                    div <= div + DIV_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster
// (15 x 12 clocks per frame) so many frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int AD = 2;
    localparam int AF = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       frame_start;
    logic       vblank_start;
    logic [5:0] frame_count;
    logic       anim_tick;
    logic [5:0] anim_frame;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ANIM_DIV(AD), .ANIM_FRAMES(AF)
    ) dut (
        .vga_clk(vga_clk),
        .Reset(Reset),
        .hs(hs),
        .vs(vs),
        .blank(blank),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .frame_start(frame_start),
        .vblank_start(vblank_start),
        .frame_count(frame_count),
        .anim_tick(anim_tick),
        .anim_frame(anim_frame)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       vbs;
        logic       tick;
        logic [5:0] fc;
        logic [5:0] af;
    } exp_t;

    exp_t sb[$];

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // reference model state
    int  m_hc = 0;
    int  m_vc = 0;
    logic m_fs = 1'b0;
    logic m_vbs = 1'b0;
    logic m_tick = 1'b0;
    int  nvb = 0;

    // directed observation state
    int   k = 0;
    int   first_vbs = -1;
    int   first_fs = -1;
    int   fs_in_f1 = 0;
    int   vs_run = 0;
    int   vs_max = 0;
    int   hs_run = 0;
    int   hs_bad = 0;
    int   obs_vb = 0;
    logic chk7 = 1'b0;
    logic wrapped = 1'b0;
    logic [5:0] prev_fc = '0;
    int   tick_vb[$];
    int   tick_af[$];

    task automatic model(input logic rst);
        exp_t e;
        if (!rst) begin
            m_hc = 0; m_vc = 0; m_fs = 0; m_vbs = 0; m_tick = 0; nvb = 0;
        end else begin
            m_tick = 1'b0;
            if (m_vbs) begin
                nvb++;
                m_tick = (nvb % AD) == 0;
            end
            if (m_hc == HT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc++;
            end
            m_fs  = (m_hc == 0) && (m_vc == 0);
            m_vbs = (m_hc == 0) && (m_vc == VV);
        end
        e.x     = 10'(m_hc);
        e.y     = 10'(m_vc);
        e.hs    = !(m_hc >= HV + HF && m_hc < HV + HF + HS);
        e.vs    = !(m_vc >= VV + VF && m_vc < VV + VF + VS);
        e.blank = (m_hc < HV) && (m_vc < VV);
        e.fs    = m_fs;
        e.vbs   = m_vbs;
        e.tick  = m_tick;
        e.fc    = 6'(nvb % 64);
        e.af    = 6'((nvb / AD) % AF);
        sb.push_back(e);
    endtask

    task automatic step(input logic rst);
        exp_t e;
        Reset = rst;
        @(posedge vga_clk);
        model(rst);
        #1;
        e = sb.pop_front();
        chk("DrawX", 32'(DrawX), 32'(e.x));
        chk("DrawY", 32'(DrawY), 32'(e.y));
        chk("hs", 32'(hs), 32'(e.hs));
        chk("vs", 32'(vs), 32'(e.vs));
        chk("blank", 32'(blank), 32'(e.blank));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("vblank_start", 32'(vblank_start), 32'(e.vbs));
        chk("anim_tick", 32'(anim_tick), 32'(e.tick));
        chk("frame_count", 32'(frame_count), 32'(e.fc));
        chk("anim_frame", 32'(anim_frame), 32'(e.af));
        if (!rst) begin
            k = 0;
        end else begin
            k++;
        end
        if (chk7) begin
            chk("fc_after_7th_vblank", 32'(frame_count), 32'd7);
            chk7 = 1'b0;
        end
        if (vblank_start) begin
            obs_vb++;
            if (first_vbs < 0) first_vbs = k;
            if (obs_vb == 7) chk7 = 1'b1;
        end
        if (frame_start) begin
            if (first_fs < 0) first_fs = k;
            if (k <= FT) fs_in_f1++;
        end
        if (anim_tick) begin
            tick_vb.push_back(obs_vb);
            tick_af.push_back(int'(anim_frame));
        end
        if (prev_fc == 6'd63 && frame_count == 6'd0) wrapped = 1'b1;
        prev_fc = frame_count;
        if (!vs) begin
            vs_run++;
        end else begin
            if (vs_run > vs_max) vs_max = vs_run;
            vs_run = 0;
        end
        if (!hs) begin
            hs_run++;
        end else begin
            if (hs_run != 0 && hs_run != HS) hs_bad++;
            hs_run = 0;
        end
    endtask

    initial begin
        int guard;
        // reset held low: outputs stay at reset values, no pulses
        for (int i = 0; i < 4; i++) step(1'b0);
        obs_vb = 0;
        // release and run past the 6-bit frame counter wrap
        for (int i = 0; i < 65 * FT; i++) step(1'b1);

        chk("first_vblank_clk", 32'(first_vbs), 32'(VV * HT));
        chk("first_frame_start_clk", 32'(first_fs), 32'(FT));
        chk("frame_start_count_f1", 32'(fs_in_f1), 32'd1);
        chk("vs_low_clocks", 32'(vs_max), 32'(VS * HT));
        chk("hs_bad_runs", 32'(hs_bad), 32'd0);
        chk("fc_wrapped", 32'(wrapped), 32'd1);
        chk("tick_count", 32'(tick_vb.size() >= 3), 32'd1);
        if (tick_vb.size() >= 3) begin
            chk("tick1_vb", 32'(tick_vb[0]), 32'd2);
            chk("tick2_vb", 32'(tick_vb[1]), 32'd4);
            chk("tick3_vb", 32'(tick_vb[2]), 32'd6);
            chk("tick1_af", 32'(tick_af[0]), 32'd1);
            chk("tick2_af", 32'(tick_af[1]), 32'd2);
            chk("tick3_af", 32'(tick_af[2]), 32'd0);
        end

        // seek to mid hsync on the last vsync line, then reset there
        guard = 0;
        while (!(DrawX == 10'(HV + HF + HS - 1) &&
                 DrawY == 10'(VV + VF + VS - 1)) && guard < 2 * FT) begin
            step(1'b1);
            guard++;
        end
        chk("seek_in_bound", 32'(guard < 2 * FT), 32'd1);
        chk("pre_reset_hs", 32'(hs), 32'd0);
        chk("pre_reset_vs", 32'(vs), 32'd0);
        step(1'b0);
        chk("rst_DrawX", 32'(DrawX), 32'd0);
        chk("rst_DrawY", 32'(DrawY), 32'd0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        chk("release_DrawX", 32'(DrawX), 32'd1);
        chk("release_frame_start", 32'(frame_start), 32'd0);
        for (int i = 0; i < FT + 5; i++) step(1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
